ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 142 ++++++++++++++
 tb/tb_ram_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port (instruction / data) arbiter in front of a single-port-pair RAM with 1-cycle read latency.
// Define RAM_ARB_RR_EN for round-robin contention; otherwise the data port has fixed priority.
module ram_arbiter #(
    parameter int unsigned DEPTH = 256,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_valid,
    input  logic [AW-1:0] i_addr,
    output logic          i_ready,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    input  logic          d_valid,
    input  logic [AW-1:0] d_addr,
    input  logic [3:0]    d_wstrb,
    input  logic [31:0]   d_wdata,
    output logic          d_ready,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic [AW-1:0] ram_waddr,
    output logic [3:0]    ram_wen,
    output logic [31:0]   ram_din,
    output logic          ram_ren,
    output logic [AW-1:0] ram_raddr,
    input  logic [31:0]   ram_dout
);

    localparam int unsigned SW = 4;
    localparam logic [SW-1:0] STARVE_MAX = '1;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_INSTR = 2'd1,
        OWN_DATA  = 2'd2
    } owner_t;

    owner_t        owner;
    logic [SW-1:0] i_starve;
    logic [SW-1:0] d_starve;
    logic [31:0]   i_hold;
    logic [31:0]   d_hold;
    logic          contention;
    logic          grant_i;
    logic          grant_d;
    logic          d_read;

`ifdef RAM_ARB_RR_EN
    logic          last_data;

    // Round-robin pointer: remembers which port was granted most recently.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_data <= 1'b1;
        end else if (grant_i) begin
            last_data <= 1'b0;
        end else if (grant_d) begin
            last_data <= 1'b1;
        end
    end
`endif

    assign contention = i_valid && d_valid;

    // Grant selection; a starved port overrides the normal policy.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (contention) begin
            if (i_starve == STARVE_MAX) begin
                grant_i = 1'b1;
            end else if (d_starve == STARVE_MAX) begin
                grant_d = 1'b1;
`ifdef RAM_ARB_RR_EN
            end else if (last_data) begin
                grant_i = 1'b1;
            end else begin
                grant_d = 1'b1;
`else
            end else begin
                grant_d = 1'b1;
`endif
            end
        end else begin
            grant_i = i_valid;
            grant_d = d_valid;
        end
    end

    assign d_read    = grant_d && (d_wstrb == 4'h0);
    assign i_ready   = grant_i;
    assign d_ready   = grant_d;
    assign ram_ren   = grant_i || d_read;
    assign ram_raddr = grant_i ? i_addr : d_addr;
    assign ram_wen   = grant_d ? d_wstrb : 4'h0;
    assign ram_waddr = d_addr;
    assign ram_din   = d_wdata;

    // Read data arrives the cycle after the grant; the owner flag steers it.
    assign i_rvalid = (owner == OWN_INSTR);
    assign d_rvalid = (owner == OWN_DATA);
    assign i_rdata  = i_rvalid ? ram_dout : i_hold;
    assign d_rdata  = d_rvalid ? ram_dout : d_hold;

    function automatic logic [SW-1:0] starve_next(input logic [SW-1:0] cnt,
                                                  input logic won, input logic lost);
        if (won) begin
            return '0;
        end
        if (lost && (cnt != STARVE_MAX)) begin
            return cnt + SW'(1);
        end
        return cnt;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner    <= OWN_NONE;
            i_hold   <= '0;
            d_hold   <= '0;
            i_starve <= '0;
            d_starve <= '0;
        end else begin
            if (grant_i) begin
                owner <= OWN_INSTR;
            end else if (d_read) begin
                owner <= OWN_DATA;
            end else begin
                owner <= OWN_NONE;
            end
            if (i_rvalid) begin
                i_hold <= ram_dout;
            end
            if (d_rvalid) begin
                d_hold <= ram_dout;
            end
            i_starve <= starve_next(i_starve, grant_i, contention && grant_d);
            d_starve <= starve_next(d_starve, grant_d, contention && grant_i);
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed, scoreboard-based bench for ram_arbiter with a behavioural byte-write RAM.
module tb_ram_arbiter;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 8;
`ifdef RAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic          i_valid;
    logic [AW-1:0] i_addr;
    logic          i_ready;
    logic          i_rvalid;
    logic [31:0]   i_rdata;
    logic          d_valid;
    logic [AW-1:0] d_addr;
    logic [3:0]    d_wstrb;
    logic [31:0]   d_wdata;
    logic          d_ready;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic [AW-1:0] ram_waddr;
    logic [3:0]    ram_wen;
    logic [31:0]   ram_din;
    logic          ram_ren;
    logic [AW-1:0] ram_raddr;
    logic [31:0]   ram_dout;

    logic [31:0]   mem [DEPTH];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [31:0]   pl_data;

    logic [31:0]   iq[$];
    logic [31:0]   dq[$];
    logic          pend_i = 1'b0;
    logic          pend_d = 1'b0;
    logic [31:0]   last_i = '0;
    logic [31:0]   last_d = '0;
    logic          gi;
    int            total = 0;
    int            bad   = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_addr(d_addr), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_waddr(ram_waddr), .ram_wen(ram_wen), .ram_din(ram_din),
        .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_dout(ram_dout)
    );

    // Behavioural RAM: byte-enabled write, registered read, plus a preload port.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        for (int b = 0; b < 4; b++) begin
            if (ram_wen[b]) mem[ram_waddr][8*b +: 8] <= ram_din[8*b +: 8];
        end
        if (ram_ren) ram_dout <= mem[ram_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] v);
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = v;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    // One clock: check read returns owed from the previous cycle, then this cycle's grant.
    task automatic cycle(input logic ei, input logic ed, input logic [31:0] edata, input string tag);
        logic wr;
        @(negedge clk);
        chk({tag, ":i_rvalid"}, 32'(i_rvalid), 32'(pend_i));
        if (pend_i && iq.size() > 0) last_i = iq.pop_front();
        chk({tag, ":i_rdata"}, i_rdata, last_i);
        chk({tag, ":d_rvalid"}, 32'(d_rvalid), 32'(pend_d));
        if (pend_d && dq.size() > 0) last_d = dq.pop_front();
        chk({tag, ":d_rdata"}, d_rdata, last_d);

        wr = ed && (d_wstrb != 4'h0);
        chk({tag, ":i_ready"}, 32'(i_ready), 32'(ei));
        chk({tag, ":d_ready"}, 32'(d_ready), 32'(ed));
        chk({tag, ":ram_ren"}, 32'(ram_ren), 32'(ei || (ed && !wr)));
        chk({tag, ":ram_wen"}, 32'(ram_wen), 32'(wr ? d_wstrb : 4'h0));
        if (ei) chk({tag, ":ram_raddr"}, 32'(ram_raddr), 32'(i_addr));
        else if (ed && !wr) chk({tag, ":ram_raddr"}, 32'(ram_raddr), 32'(d_addr));
        if (wr) begin
            chk({tag, ":ram_waddr"}, 32'(ram_waddr), 32'(d_addr));
            chk({tag, ":ram_din"}, ram_din, d_wdata);
        end

        pend_i = ei;
        pend_d = ed && !wr;
        if (pend_i) iq.push_back(edata);
        if (pend_d) dq.push_back(edata);
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        i_valid = 1'b0; i_addr = '0;
        d_valid = 1'b0; d_addr = '0; d_wstrb = 4'h0; d_wdata = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        #1;
        preload(8'h10, 32'hDEADBEEF);
        preload(8'h05, 32'h11223344);
        preload(8'h20, 32'hCAFEF00D);
        for (int k = 1; k <= 3; k++) preload(AW'(k), 32'hA000_0000 | 32'(k));

        // Reset values with no requests
        cycle(1'b0, 1'b0, '0, "reset0");
        cycle(1'b0, 1'b0, '0, "reset1");
        resetn = 1'b1;
        cycle(1'b0, 1'b0, '0, "idle");

        // Lone instruction read, then rdata hold
        i_valid = 1'b1; i_addr = 8'h10;
        cycle(1'b1, 1'b0, 32'hDEADBEEF, "instr_rd");
        i_valid = 1'b0;
        cycle(1'b0, 1'b0, '0, "instr_rv");
        cycle(1'b0, 1'b0, '0, "instr_hold");

        // Byte write into 0x05 followed by a read-back
        d_valid = 1'b1; d_addr = 8'h05; d_wstrb = 4'b0010; d_wdata = 32'h0000AB00;
        cycle(1'b0, 1'b1, '0, "byte_wr");
        d_wstrb = 4'h0;
        cycle(1'b0, 1'b1, 32'h1122AB44, "byte_rd");
        d_valid = 1'b0;
        cycle(1'b0, 1'b0, '0, "byte_rv");

        // Back-to-back data reads
        d_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            d_addr = AW'(k);
            cycle(1'b0, 1'b1, 32'hA000_0000 | 32'(k), $sformatf("b2b%0d", k));
        end
        d_valid = 1'b0;
        cycle(1'b0, 1'b0, '0, "b2b_tail0");
        cycle(1'b0, 1'b0, '0, "b2b_tail1");

        // Full-word write with no read return, then read it back
        d_valid = 1'b1; d_addr = 8'h30; d_wstrb = 4'hF; d_wdata = 32'h5A5A5A5A;
        cycle(1'b0, 1'b1, '0, "wr_only");
        d_valid = 1'b0; d_wstrb = 4'h0;
        cycle(1'b0, 1'b0, '0, "wr_only_norv");
        d_valid = 1'b1;
        cycle(1'b0, 1'b1, 32'h5A5A5A5A, "wr_readback");
        d_valid = 1'b0;
        cycle(1'b0, 1'b0, '0, "wr_readback_rv");

        // Contention: both ports request reads continuously
        i_valid = 1'b1; i_addr = 8'h10;
        d_valid = 1'b1; d_addr = 8'h20;
        for (int k = 0; k < 17; k++) begin
            gi = RR ? (k % 2 == 0) : (k == 15);
            cycle(gi, !gi, gi ? 32'hDEADBEEF : 32'hCAFEF00D, $sformatf("arb%0d", k));
        end
        i_valid = 1'b0; d_valid = 1'b0;
        cycle(1'b0, 1'b0, '0, "arb_tail0");
        cycle(1'b0, 1'b0, '0, "arb_tail1");

        // Reset asserted the cycle after an instruction grant
        i_valid = 1'b1; i_addr = 8'h10;
        cycle(1'b1, 1'b0, 32'hDEADBEEF, "rst_grant");
        resetn = 1'b0; i_valid = 1'b0;
        #1;
        chk("rst_async:i_rvalid", 32'(i_rvalid), 32'd0);
        chk("rst_async:i_rdata", i_rdata, 32'd0);
        chk("rst_async:d_rdata", d_rdata, 32'd0);
        iq.delete(); dq.delete();
        pend_i = 1'b0; pend_d = 1'b0; last_i = '0; last_d = '0;
        cycle(1'b0, 1'b0, '0, "rst_hold0");
        cycle(1'b0, 1'b0, '0, "rst_hold1");
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, '0, $sformatf("rst_after%0d", k));

        chk("iq_empty", 32'(iq.size()), 32'd0);
        chk("dq_empty", 32'(dq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
